// File: rtl/nonce_result_collector.sv
// nonce_result_collector
//   Sits between the core result bus and the host return path. It rebuilds
//   full nonces from per-beat core results (session base + core index) and
//   queues the hits in a small FIFO. Depending on MODE_FIRST a session stops
//   at the first hit or runs over the whole broadcast range. When a session
//   ends, a one-cycle summary strobe is raised.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   valid_i         result beat valid
//   newblock_i      with valid_i: first beat of a new session
//   success_i       reporting core found a hit
//   nonce_prefix_i  index of the reporting core
//   valid_o         one-cycle session summary strobe
//   success_o       session had at least one hit (only while valid_o)
//   first_nonce_o   first hit of the last finished session
//   hit_count_o     hits in the last finished session, dropped ones included
//   overflow_o      last finished session dropped at least one hit
//   hit_valid_o     FIFO head valid
//   hit_ready_i     consumer takes the FIFO head
//   hit_nonce_o     FIFO head nonce
module nonce_result_collector #(
   parameter int NUM_CORES     = 10,
   parameter int BROADCAST_CNT = 100,
   parameter int NONCE_W       = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter bit MODE_FIRST    = 1'b1,
   parameter int PARTITIONBITS = $clog2(NUM_CORES),
   localparam int CNT_W        = $clog2(BROADCAST_CNT + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic                     newblock_i,
   input  logic                     success_i,
   input  logic [PARTITIONBITS-1:0] nonce_prefix_i,
   output logic                     valid_o,
   output logic                     success_o,
   output logic [NONCE_W-1:0]       first_nonce_o,
   output logic [CNT_W-1:0]         hit_count_o,
   output logic                     overflow_o,
   output logic                     hit_valid_o,
   input  logic                     hit_ready_i,
   output logic [NONCE_W-1:0]       hit_nonce_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [NONCE_W-1:0]     NC_W = NONCE_W'(NUM_CORES);
   localparam logic [NONCE_W-1:0]     BC_W = NONCE_W'(BROADCAST_CNT);
   // one spare bit so a power-of-two core count is still representable
   localparam logic [PARTITIONBITS:0] NC_P = (PARTITIONBITS + 1)'(NUM_CORES);

   typedef enum logic [1:0] {IDLE, READING, SUMMARY} state_t;

   state_t               state, state_n;
   logic [NONCE_W-1:0]   base, first_q;
   logic [CNT_W-1:0]     count;
   logic                 ovf_q;

   logic [NONCE_W-1:0]   mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;

   logic                 start, beat, hit, last, push, pop, full, empty;
   logic [NONCE_W-1:0]   base_use, cand, first_n;
   logic [CNT_W-1:0]     count_base, count_n;
   logic                 ovf_n;
   logic [AW-1:0]        waddr;

   always_comb begin
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      empty = (wr_ptr == rd_ptr);
      pop   = !empty && hit_ready_i;

      // a newblock beat opens a session from any state and is itself beat 0
      start      = valid_i && newblock_i;
      beat       = valid_i && (newblock_i || state == READING);
      base_use   = start ? '0 : base;
      cand       = base_use + NONCE_W'(nonce_prefix_i);
      hit        = beat && success_i && ({1'b0, nonce_prefix_i} < NC_P) && (cand < BC_W);
      last       = beat && ((base_use + NC_W >= BC_W) || (MODE_FIRST && hit));

      count_base = start ? '0 : count;
      count_n    = count_base + CNT_W'(hit);
      first_n    = start ? '0 : first_q;
      if (hit && count_base == '0)
         first_n = cand;

      // the flush on start empties the FIFO, so that push can never drop
      push  = hit && (start || !full || pop);
      ovf_n = (start ? 1'b0 : ovf_q) | (hit && !push);
      waddr = start ? '0 : wr_ptr[AW-1:0];

      state_n = state;
      case (state)
         IDLE:    state_n = IDLE;
         READING: state_n = READING;
         SUMMARY: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (beat)
         state_n = last ? SUMMARY : READING;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         base          <= '0;
         count         <= '0;
         first_q       <= '0;
         ovf_q         <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         first_nonce_o <= '0;
         hit_count_o   <= '0;
         overflow_o    <= 1'b0;
      end else begin
         state <= state_n;
         if (beat) begin
            base    <= base_use + NC_W;
            count   <= count_n;
            first_q <= first_n;
            ovf_q   <= ovf_n;
         end
         // summary values are captured at the last beat and then held
         if (last) begin
            hit_count_o   <= count_n;
            first_nonce_o <= first_n;
            overflow_o    <= ovf_n;
         end
         if (start) begin
            rd_ptr <= '0;
            wr_ptr <= push ? (AW + 1)'(1) : '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[waddr] <= cand;
   end

   assign valid_o     = (state == SUMMARY);
   assign success_o   = valid_o && (hit_count_o != '0);
   assign hit_valid_o = !empty;
   assign hit_nonce_o = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
